// File: rtl/ram_seq_ctrl_if.sv
// Request/response handshake bundle between a requester and ram_seq_ctrl.
// The master issues requests and consumes responses; the slave is the controller.
interface ram_seq_ctrl_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/ram_seq_ctrl.sv
// Single-outstanding request/response sequencer in front of a bank of
// negedge-read storage cells: decode, one-cycle access, registered response.
module ram_seq_ctrl #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4,
  localparam int N = 2**ADDR_W
) (
  input  logic                CLK_,
  input  logic                CLR_,
  ram_seq_ctrl_if.slave       bus,
  output logic [N-1:0]        cell_sel,
  output logic                R_W_,
  output logic [DATA_W-1:0]   data_in,
  input  logic [N*DATA_W-1:0] cell_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_reg, state_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;

  logic                req_ready_reg, req_ready_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic                rsp_we_reg, rsp_we_next;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic [N-1:0]        cell_sel_reg, cell_sel_next;
  logic                r_w_reg, r_w_next;
  logic [DATA_W-1:0]   data_in_reg, data_in_next;

  logic                accept;
  logic [N-1:0]        sel_dec;
  logic [DATA_W-1:0]   dout_slice [N];

  // req_ready mirrors state_reg == IDLE, so accepting never depends on an output path
  assign accept = (state_reg == IDLE) && bus.req_valid;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
      assign sel_dec[gi]    = (addr_next == ADDR_W'(gi));
      assign dout_slice[gi] = cell_dout[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_ff @(posedge CLK_ or negedge CLR_) begin
    if (!CLR_) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_we_reg    <= 1'b0;
      rsp_rdata_reg <= '0;
      cell_sel_reg  <= '0;
      r_w_reg       <= 1'b0;
      data_in_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_we_reg    <= rsp_we_next;
      rsp_rdata_reg <= rsp_rdata_next;
      cell_sel_reg  <= cell_sel_next;
      r_w_reg       <= r_w_next;
      data_in_reg   <= data_in_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = ACCESS;
          we_next    = bus.req_we;
          addr_next  = bus.req_addr;
          wdata_next = bus.req_wdata;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so they register in step with it
  always_comb begin
    req_ready_next = (state_next == IDLE);
    rsp_valid_next = (state_next == RESP);
    cell_sel_next  = '0;
    r_w_next       = 1'b0;
    data_in_next   = '0;
    rsp_we_next    = rsp_we_reg;
    rsp_rdata_next = rsp_rdata_reg;
    if (state_next == ACCESS) begin
      cell_sel_next = sel_dec;
      r_w_next      = we_next;
      data_in_next  = we_next ? wdata_next : '0;
    end
    // The cell registered its data_out on the falling edge inside ACCESS
    if (state_reg == ACCESS) begin
      rsp_we_next    = we_reg;
      rsp_rdata_next = we_reg ? '0 : dout_slice[addr_reg];
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_we    = rsp_we_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign cell_sel      = cell_sel_reg;
  assign R_W_          = r_w_reg;
  assign data_in       = data_in_reg;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl with a behavioural bank of four
// negedge-read storage cells hanging off the cell bus.
module tb_ram_seq_ctrl;

  logic        CLK_;
  logic        CLR_;
  logic [3:0]  cell_sel;
  logic        R_W_;
  logic [3:0]  data_in;
  logic [15:0] cell_dout;
  logic [3:0]  mem [4];

  int checks = 0;
  int errors = 0;

  ram_seq_ctrl_if #(.ADDR_W(2), .DATA_W(4)) bus ();

  ram_seq_ctrl #(.ADDR_W(2), .DATA_W(4)) dut (
    .CLK_      (CLK_),
    .CLR_      (CLR_),
    .bus       (bus),
    .cell_sel  (cell_sel),
    .R_W_      (R_W_),
    .data_in   (data_in),
    .cell_dout (cell_dout)
  );

  initial CLK_ = 1'b0;
  always #5 CLK_ = ~CLK_;

  // Cell model: write on rising edge, read registered on falling edge
  always @(posedge CLK_) begin
    for (int k = 0; k < 4; k++)
      if (cell_sel[k] && R_W_) mem[k] <= data_in;
  end

  always @(negedge CLK_) begin
    for (int k = 0; k < 4; k++)
      cell_dout[k*4 +: 4] <= (cell_sel[k] && !R_W_) ? mem[k] : 4'h0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_req(input logic we, input logic [1:0] a, input logic [3:0] d,
                          output logic [3:0] sel, output logic rw,
                          output logic [3:0] din, output bit to);
    bit acc;
    to = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      acc = bus.req_ready;
      @(posedge CLK_); #1;
      if (acc) begin
        to = 1'b0;
        break;
      end
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 2'd0;
    bus.req_wdata = 4'h0;
    sel = cell_sel;
    rw  = R_W_;
    din = data_in;
  endtask

  task automatic wait_rsp(output int edges, output bit to);
    edges = 0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK_); #1;
      edges++;
      if (bus.rsp_valid) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    CLR_ = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 2'd0;
    bus.req_wdata = 4'h0; bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) mem[k] = 4'h0;
    repeat (3) @(posedge CLK_);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || cell_sel !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: rsp_valid=%b cell_sel=%b, want 0 0000", bus.rsp_valid, cell_sel);
    end
    @(negedge CLK_); CLR_ = 1'b1;
    @(posedge CLK_); #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b, want 1 0", bus.req_ready, bus.rsp_valid);
    end
    checks++;
    if (cell_sel !== 4'b0000 || R_W_ !== 1'b0 || data_in !== 4'h0) begin
      errors++;
      $display("FAIL reset_cellbus: cell_sel=%b R_W_=%b data_in=%h, want 0000 0 0", cell_sel, R_W_, data_in);
    end
    checks++;
    if (bus.rsp_we !== 1'b0 || bus.rsp_rdata !== 4'h0) begin
      errors++;
      $display("FAIL reset_rsp: rsp_we=%b rsp_rdata=%h, want 0 0", bus.rsp_we, bus.rsp_rdata);
    end
    $display("reset: req_ready=%b cell_sel=%b", bus.req_ready, cell_sel);
  endtask

  task automatic test_write_read();
    logic [3:0] sel, din;
    logic rw;
    bit to, to2;
    int edges;
    send_req(1'b1, 2'd2, 4'hA, sel, rw, din, to);
    checks++;
    if (to || sel !== 4'b0100 || rw !== 1'b1 || din !== 4'hA) begin
      errors++;
      $display("FAIL wr_access: to=%b sel=%b rw=%b din=%h, want 0 0100 1 a", to, sel, rw, din);
    end
    wait_rsp(edges, to2);
    checks++;
    if (to2 || bus.rsp_we !== 1'b1 || bus.rsp_rdata !== 4'h0) begin
      errors++;
      $display("FAIL wr_rsp: to=%b rsp_we=%b rsp_rdata=%h, want 0 1 0", to2, bus.rsp_we, bus.rsp_rdata);
    end
    $display("write addr=2 data=a: sel=%b rsp_we=%b", sel, bus.rsp_we);
    @(posedge CLK_); #1;
    send_req(1'b0, 2'd2, 4'h0, sel, rw, din, to);
    checks++;
    if (to || sel !== 4'b0100 || rw !== 1'b0 || din !== 4'h0) begin
      errors++;
      $display("FAIL rd_access: to=%b sel=%b rw=%b din=%h, want 0 0100 0 0", to, sel, rw, din);
    end
    wait_rsp(edges, to2);
    // one edge after the accept edge, valid is presented for the T+2 edge
    checks++;
    if (to2 || edges != 1) begin
      errors++;
      $display("FAIL rd_latency: to=%b edges=%0d, want 0 1", to2, edges);
    end
    checks++;
    if (bus.rsp_we !== 1'b0 || bus.rsp_rdata !== 4'hA) begin
      errors++;
      $display("FAIL rd_data: rsp_we=%b rsp_rdata=%h, want 0 a", bus.rsp_we, bus.rsp_rdata);
    end
    $display("read addr=2: rsp_rdata=%h edges=%0d", bus.rsp_rdata, edges);
    @(posedge CLK_); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_release: rsp_valid=%b req_ready=%b, want 0 1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_fill();
    logic [1:0] order [4];
    logic [3:0] exp_d [4];
    logic [3:0] exp_s [4];
    logic [3:0] sel, din;
    logic rw;
    bit to, to2;
    int edges;
    order = '{2'd3, 2'd0, 2'd2, 2'd1};
    exp_d = '{4'h8, 4'h5, 4'h7, 4'h6};
    exp_s = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
    for (int k = 0; k < 4; k++) begin
      send_req(1'b1, 2'(k), 4'(5 + k), sel, rw, din, to);
      wait_rsp(edges, to2);
      checks++;
      if (to || to2 || rw !== 1'b1 || din !== 4'(5 + k)) begin
        errors++;
        $display("FAIL fill_wr%0d: to=%b/%b rw=%b din=%h, want 0/0 1 %h", k, to, to2, rw, din, 4'(5 + k));
      end
      $display("fill write addr=%0d data=%h sel=%b", k, din, sel);
      @(posedge CLK_); #1;
    end
    for (int k = 0; k < 4; k++) begin
      send_req(1'b0, order[k], 4'h0, sel, rw, din, to);
      wait_rsp(edges, to2);
      checks++;
      if (to || to2 || sel !== exp_s[k] || bus.rsp_rdata !== exp_d[k]) begin
        errors++;
        $display("FAIL fill_rd%0d: to=%b/%b sel=%b rdata=%h, want 0/0 %b %h",
                 order[k], to, to2, sel, bus.rsp_rdata, exp_s[k], exp_d[k]);
      end
      $display("fill read addr=%0d sel=%b rdata=%h", order[k], sel, bus.rsp_rdata);
      @(posedge CLK_); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] sel, din;
    logic rw;
    bit to, to2;
    int edges;
    bus.rsp_ready = 1'b0;
    send_req(1'b0, 2'd1, 4'h0, sel, rw, din, to);
    wait_rsp(edges, to2);
    checks++;
    if (to || to2 || bus.rsp_rdata !== 4'h6) begin
      errors++;
      $display("FAIL bp_first: to=%b/%b rdata=%h, want 0/0 6", to, to2, bus.rsp_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = (i % 2 == 0);
      bus.req_we    = 1'b1;
      bus.req_addr  = 2'd3;
      bus.req_wdata = 4'hC;
      @(posedge CLK_); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 4'h6 || bus.req_ready !== 1'b0 || cell_sel !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d: rsp_valid=%b rdata=%h req_ready=%b sel=%b, want 1 6 0 0000",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, cell_sel);
      end
      $display("backpressure cycle %0d: rsp_valid=%b rdata=%h", i, bus.rsp_valid, bus.rsp_rdata);
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 2'd0; bus.req_wdata = 4'h0;
    bus.rsp_ready = 1'b1;
    @(posedge CLK_); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b, want 0 1", bus.rsp_valid, bus.req_ready);
    end
    @(posedge CLK_); #1;
    checks++;
    if (cell_sel !== 4'b0000 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_accept: sel=%b req_ready=%b, want 0000 1", cell_sel, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [3:0] sel, din;
    logic rw;
    bit to, to2;
    int edges;
    send_req(1'b1, 2'd0, 4'h3, sel, rw, din, to);
    wait_rsp(edges, to2);
    @(posedge CLK_); #1;
    send_req(1'b1, 2'd0, 4'hF, sel, rw, din, to);
    checks++;
    if (to || sel !== 4'b0001 || rw !== 1'b1 || din !== 4'hF) begin
      errors++;
      $display("FAIL rst_mid_access: to=%b sel=%b rw=%b din=%h, want 0 0001 1 f", to, sel, rw, din);
    end
    #2 CLR_ = 1'b0;
    #1;
    checks++;
    if (cell_sel !== 4'b0000 || R_W_ !== 1'b0 || data_in !== 4'h0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle: sel=%b R_W_=%b data_in=%h rsp_valid=%b, want 0000 0 0 0",
               cell_sel, R_W_, data_in, bus.rsp_valid);
    end
    @(posedge CLK_);
    @(negedge CLK_); CLR_ = 1'b1;
    @(posedge CLK_); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_norsp: rsp_valid=%b req_ready=%b, want 0 1", bus.rsp_valid, bus.req_ready);
    end
    send_req(1'b0, 2'd0, 4'h0, sel, rw, din, to);
    wait_rsp(edges, to2);
    checks++;
    if (to || to2 || bus.rsp_rdata !== 4'h3) begin
      errors++;
      $display("FAIL rst_mid_readback: to=%b/%b rdata=%h, want 0/0 3", to, to2, bus.rsp_rdata);
    end
    $display("reset mid-write: readback addr=0 rdata=%h", bus.rsp_rdata);
    @(posedge CLK_); #1;
  endtask

  task automatic test_back_to_back();
    bit exp_v [9];
    bit exp_r [9];
    exp_v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_r = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 2'd3;
    for (int i = 0; i < 9; i++) begin
      @(posedge CLK_); #1;
      checks++;
      if (bus.rsp_valid !== exp_v[i] || bus.req_ready !== exp_r[i] ||
          (exp_v[i] && bus.rsp_rdata !== 4'h8)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: rsp_valid=%b req_ready=%b rdata=%h, want %b %b 8",
                 i, bus.rsp_valid, bus.req_ready, bus.rsp_rdata, exp_v[i], exp_r[i]);
      end
      $display("back-to-back cycle %0d: rsp_valid=%b req_ready=%b", i, bus.rsp_valid, bus.req_ready);
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = 2'd0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fill();
    test_backpressure();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
